// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback, and drives every datapath enable and mux select.
module mips_multicycle_ctrl #(
    parameter int OPC_W = 6,
    parameter int ST_W  = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [OPC_W-1:0] i_opcode,
    input  logic             i_mem_ready,
    output logic [1:0]       o_ALUOp,
    output logic             o_ALUSrcA,
    output logic [1:0]       o_ALUSrcB,
    output logic [1:0]       o_PCSrc,
    output logic             o_IorD,
    output logic             o_IRWrite,
    output logic             o_PCWrite,
    output logic             o_Branch,
    output logic             o_MemWrite,
    output logic             o_MemtoReg,
    output logic             o_RegDst,
    output logic             o_RegWrite,
    output logic [ST_W-1:0]  o_state,
    output logic             o_illegal
);

    typedef enum logic [ST_W-1:0] {
        S_FETCH    = ST_W'(0),
        S_DECODE   = ST_W'(1),
        S_MEMADR   = ST_W'(2),
        S_MEMREAD  = ST_W'(3),
        S_MEMWB    = ST_W'(4),
        S_MEMWRITE = ST_W'(5),
        S_EXECUTE  = ST_W'(6),
        S_ALUWB    = ST_W'(7),
        S_BRANCH   = ST_W'(8),
        S_ADDIEXEC = ST_W'(9),
        S_ADDIWB   = ST_W'(10),
        S_JUMP     = ST_W'(11)
    } state_e;

    localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(6'b000000);
    localparam logic [OPC_W-1:0] OP_J     = OPC_W'(6'b000010);
    localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(6'b000100);
    localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(6'b001000);
    localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(6'b100011);
    localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(6'b101011);

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can
        // leave a signal unassigned and infer a latch.
        state_d    = state_q;
        illegal_d  = 1'b0;
        o_ALUOp    = 2'b00;
        o_ALUSrcA  = 1'b0;
        o_ALUSrcB  = 2'b00;
        o_PCSrc    = 2'b00;
        o_IorD     = 1'b0;
        o_IRWrite  = 1'b0;
        o_PCWrite  = 1'b0;
        o_Branch   = 1'b0;
        o_MemWrite = 1'b0;
        o_MemtoReg = 1'b0;
        o_RegDst   = 1'b0;
        o_RegWrite = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                o_ALUSrcB = 2'b01;
                // Reset leaves us in FETCH; the rst_n term keeps IR/PC frozen meanwhile.
                o_IRWrite = i_mem_ready & i_rst_n;
                o_PCWrite = i_mem_ready & i_rst_n;
                if (i_mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                o_ALUSrcB = 2'b11;
                case (i_opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                o_ALUSrcA = 1'b1;
                o_ALUSrcB = 2'b10;
                if (i_opcode == OP_LW)      state_d = S_MEMREAD;
                else if (i_opcode == OP_SW) state_d = S_MEMWRITE;
                else                        state_d = S_FETCH;
            end
            S_MEMREAD: begin
                o_IorD = 1'b1;
                if (i_mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                o_MemtoReg = 1'b1;
                o_RegWrite = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                o_IorD     = 1'b1;
                o_MemWrite = i_mem_ready;
                if (i_mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                o_ALUSrcA = 1'b1;
                o_ALUOp   = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                o_RegDst   = 1'b1;
                o_RegWrite = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                o_ALUSrcA = 1'b1;
                o_ALUOp   = 2'b01;
                o_PCSrc   = 2'b01;
                o_Branch  = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDIEXEC: begin
                o_ALUSrcA = 1'b1;
                o_ALUSrcB = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                o_RegWrite = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                o_PCSrc   = 2'b10;
                o_PCWrite = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign o_state   = state_q;
    assign o_illegal = illegal_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: expands each instruction into its expected
// state/control trace and compares the DUT cycle by cycle under random stalls.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       ready;
    logic [1:0] alu_op, alu_src_b, pc_src;
    logic       alu_src_a, iord, ir_write, pc_write, branch, mem_write;
    logic       mem_to_reg, reg_dst, reg_write, illegal;
    logic [3:0] state;
    logic [14:0] act;

    mips_multicycle_ctrl #(.OPC_W(6), .ST_W(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_mem_ready(ready),
        .o_ALUOp(alu_op), .o_ALUSrcA(alu_src_a), .o_ALUSrcB(alu_src_b),
        .o_PCSrc(pc_src), .o_IorD(iord), .o_IRWrite(ir_write),
        .o_PCWrite(pc_write), .o_Branch(branch), .o_MemWrite(mem_write),
        .o_MemtoReg(mem_to_reg), .o_RegDst(reg_dst), .o_RegWrite(reg_write),
        .o_state(state), .o_illegal(illegal)
    );

    always #5 clk = ~clk;

    assign act = {alu_op, alu_src_a, alu_src_b, pc_src, iord, ir_write, pc_write,
                  branch, mem_write, mem_to_reg, reg_dst, reg_write};

    typedef enum {C_LW, C_SW, C_R, C_BEQ, C_ADDI, C_J, C_ILL} cls_e;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

    int n_checks = 0;
    int n_pass   = 0;
    bit illegal_pend = 1'b0;
    int exp_st[$];
    bit exp_rd[$];

    function automatic cls_e op_class(input logic [5:0] op);
        case (op)
            OP_LW:   return C_LW;
            OP_SW:   return C_SW;
            OP_R:    return C_R;
            OP_BEQ:  return C_BEQ;
            OP_ADDI: return C_ADDI;
            OP_J:    return C_J;
            default: return C_ILL;
        endcase
    endfunction

    // Expected control word {ALUOp,SrcA,SrcB,PCSrc,IorD,IRW,PCW,Br,MemW,MtoR,RegDst,RegW}.
    function automatic logic [14:0] ctrl_word(input int st, input bit rdy);
        logic [1:0] aop = 2'b00, srcb = 2'b00, pcs = 2'b00;
        logic srca = 0, iod = 0, irw = 0, pcw = 0, br = 0, mw = 0, mtr = 0, rd = 0, rw = 0;
        case (st)
            0:  begin srcb = 2'b01; irw = rdy; pcw = rdy; end
            1:  srcb = 2'b11;
            2:  begin srca = 1; srcb = 2'b10; end
            3:  iod = 1;
            4:  begin mtr = 1; rw = 1; end
            5:  begin iod = 1; mw = rdy; end
            6:  begin aop = 2'b10; srca = 1; end
            7:  begin rd = 1; rw = 1; end
            8:  begin aop = 2'b01; srca = 1; pcs = 2'b01; br = 1; end
            9:  begin srca = 1; srcb = 2'b10; end
            10: rw = 1;
            11: begin pcs = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {aop, srca, srcb, pcs, iod, irw, pcw, br, mw, mtr, rd, rw};
    endfunction

    task automatic push(input int s, input bit r);
        exp_st.push_back(s);
        exp_rd.push_back(r);
    endtask

    // Entered and left just after a rising edge with the DUT in FETCH.
    task automatic run_instr(input logic [5:0] op, input int fst, input int mst);
        cls_e cls = op_class(op);
        exp_st.delete();
        exp_rd.delete();
        for (int i = 0; i < fst; i++) push(0, 1'b0);
        push(0, 1'b1);
        push(1, 1'($urandom));
        case (cls)
            C_LW: begin
                push(2, 1'($urandom));
                for (int i = 0; i < mst; i++) push(3, 1'b0);
                push(3, 1'b1);
                push(4, 1'($urandom));
            end
            C_SW: begin
                push(2, 1'($urandom));
                for (int i = 0; i < mst; i++) push(5, 1'b0);
                push(5, 1'b1);
            end
            C_R:    begin push(6, 1'($urandom)); push(7, 1'($urandom)); end
            C_BEQ:  push(8, 1'($urandom));
            C_ADDI: begin push(9, 1'($urandom)); push(10, 1'($urandom)); end
            C_J:    push(11, 1'($urandom));
            default: ;
        endcase
        for (int i = 0; i < exp_st.size(); i++) begin
            ready  = exp_rd[i];
            opcode = (exp_st[i] == 1 || exp_st[i] == 2) ? op : 6'($urandom);
            @(negedge clk);
            n_checks++;
            if (state !== 4'(exp_st[i]))
                $display("FAIL state op=%b step%0d: got %0d want %0d", op, i, state, exp_st[i]);
            else n_pass++;
            n_checks++;
            if (act !== ctrl_word(exp_st[i], exp_rd[i]))
                $display("FAIL ctrl op=%b step%0d st%0d: got %h want %h", op, i, exp_st[i],
                         act, ctrl_word(exp_st[i], exp_rd[i]));
            else n_pass++;
            n_checks++;
            if (illegal !== illegal_pend)
                $display("FAIL illegal op=%b step%0d: got %b want %b", op, i, illegal, illegal_pend);
            else n_pass++;
            illegal_pend = (exp_st[i] == 1 && cls == C_ILL);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        ready  = 1'b1;
        opcode = OP_R;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (state !== 4'd0 || act !== ctrl_word(0, 1'b0) || illegal !== 1'b0)
                $display("FAIL reset_hold: got st=%0d ctrl=%h ill=%b want st=0 ctrl=%h ill=0",
                         state, act, illegal, ctrl_word(0, 1'b0));
            else n_pass++;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        illegal_pend = 1'b0;
        run_instr(OP_R, 0, 0);
    endtask

    task automatic test_lw;
        run_instr(OP_LW, 0, 0);
        run_instr(OP_LW, 2, 2);
    endtask

    task automatic test_sw_stall;
        run_instr(OP_SW, 0, 3);
    endtask

    task automatic test_branch_jump;
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_J, 1, 0);
        run_instr(OP_ADDI, 0, 0);
    endtask

    task automatic test_illegal;
        run_instr(6'b111111, 0, 0);
        run_instr(OP_J, 0, 0);
        run_instr(6'b010101, 1, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(OP_R, 0, 0);
    endtask

    task automatic check_in_reset(input string tag);
        n_checks++;
        if (state !== 4'd0 || reg_write !== 1'b0 || ir_write !== 1'b0 ||
            pc_write !== 1'b0 || mem_write !== 1'b0)
            $display("FAIL %s: got st=%0d rw=%b irw=%b pcw=%b mw=%b want st=0 all enables 0",
                     tag, state, reg_write, ir_write, pc_write, mem_write);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        // Abort in MEMWB: lw runs FETCH, DECODE, MEMADR, MEMREAD with ready high.
        ready  = 1'b1;
        opcode = OP_LW;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (state !== 4'd4 || reg_write !== 1'b1)
            $display("FAIL memwb_reach: got st=%0d rw=%b want st=4 rw=1", state, reg_write);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1 check_in_reset("reset_in_memwb");
        @(posedge clk);
        #1 check_in_reset("reset_held_memwb");
        ready = 1'b0;
        rst_n = 1'b1;
        illegal_pend = 1'b0;
        run_instr(OP_J, 2, 0);

        // Abort during a FETCH stall; ready rising while still in reset must not load IR/PC.
        ready = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_in_reset("reset_in_fetch");
        ready = 1'b1;
        #1 check_in_reset("reset_fetch_ready");
        @(posedge clk);
        #1 check_in_reset("reset_held_fetch");
        ready = 1'b0;
        rst_n = 1'b1;
        run_instr(OP_R, 1, 0);
    endtask

    task automatic test_random;
        logic [5:0] legal [6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
        logic [5:0] op;
        repeat (60) begin
            if ($urandom_range(0, 5) == 0) op = 6'($urandom);
            else op = legal[$urandom_range(0, 5)];
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic test_back_to_back;
        run_instr(OP_SW, 0, 0);
        run_instr(OP_LW, 0, 0);
        run_instr(OP_BEQ, 0, 0);
        run_instr(6'b000001, 0, 0);
        run_instr(6'b111110, 0, 0);
        run_instr(OP_ADDI, 0, 0);
    endtask

    initial begin
        test_reset;
        test_lw;
        test_sw_stall;
        test_branch_jump;
        test_illegal;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS datapath variant.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the 2-bit ALUOp consumed by the existing ALU decoder, plus all datapath enables and muxes.
- Stalls on a memory ready handshake and flags unsupported opcodes.

Parameters:
- OPC_W, 6, opcode field width
- ST_W, 4, state register width

Ports:
- i_clk  input  1  clock; all state changes on the rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_opcode  input  OPC_W  instr[31:26] from the instruction register
- i_mem_ready  input  1  memory completes the current access this cycle
- o_ALUOp  output  2  00 add, 01 sub, 10 use funct field
- o_ALUSrcA  output  1  0 = PC, 1 = register A
- o_ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- o_PCSrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- o_IorD  output  1  memory address: 0 = PC, 1 = ALUOut
- o_IRWrite  output  1  instruction register load
- o_PCWrite  output  1  unconditional PC load
- o_Branch  output  1  PC load qualified by zero (beq)
- o_MemWrite  output  1  memory write strobe
- o_MemtoReg  output  1  writeback source: 1 = memory data
- o_RegDst  output  1  destination register: 1 = rd, 0 = rt
- o_RegWrite  output  1  register file write
- o_state  output  ST_W  current state, for debug and the bench
- o_illegal  output  1  one-cycle pulse on an unsupported opcode

Behaviour:
- Single state register, binary encoded:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11
- Codes 12-15 are unreachable; if ever entered, go to FETCH next cycle.
- Reset (i_rst_n low, asynchronous): state = FETCH, o_illegal = 0.
  - While in reset all outputs show FETCH decode, with o_IRWrite = o_PCWrite = 0.
- Outputs are combinational decode of state. Exception: o_IRWrite, o_PCWrite in FETCH and o_MemWrite in MEMWRITE are ANDed with i_mem_ready.
- Any output not listed for a state is 0.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=PCWrite=ready.
  - Stays in FETCH until i_mem_ready, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXECUTE
  - 000100 (beq) -> BRANCH
  - 001000 (addi) -> ADDIEXEC
  - 000010 (j) -> JUMP
  - any other opcode -> FETCH, with o_illegal = 1 registered for exactly the next cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEMREAD if lw, MEMWRITE if sw.
  - Opcode is sampled again here; the IR is stable.
- MEMREAD: IorD=1; waits for ready -> MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- MEMWRITE: IorD=1, MemWrite=ready; waits for ready -> FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1 -> FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
- JUMP: PCSrc=10, PCWrite=1 -> FETCH.
- Cycles per instruction, no stalls:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal 2.
  - Each cycle of i_mem_ready low adds one cycle in FETCH, MEMREAD or MEMWRITE.
- Reset asserted mid-instruction: abort immediately to FETCH. No partial RegWrite or MemWrite may be issued after the reset edge.
- i_opcode is only sampled in DECODE and MEMADR; changes elsewhere are ignored.

Test Plan:
- Reset held, then released with i_mem_ready=1 and opcode 000000 -> state sequence 0,1,6,7,0. o_ALUOp=10 only in state 6; o_RegWrite=1 and o_RegDst=1 only in state 7.
- lw (100011), ready=1 -> states 0,1,2,3,4,0. o_IorD=1 in state 3; o_MemtoReg=o_RegWrite=1 in state 4; o_ALUSrcB=10 in state 2.
- sw (101011) with ready low 3 cycles in MEMWRITE -> state 5 held 4 cycles. o_MemWrite high only in the ready cycle, then FETCH.
- beq (000100) -> states 0,1,8,0. In state 8: o_ALUOp=01, o_Branch=1, o_PCSrc=01. j (000010) -> 0,1,11,0 with o_PCSrc=10 and o_PCWrite=1.
- Opcode 111111 -> states 0,1,0. o_illegal high exactly one cycle; no RegWrite or MemWrite at any point.
- i_rst_n dropped mid-MEMWB and mid-FETCH stall -> state=0 asynchronously. o_RegWrite, o_IRWrite and o_PCWrite are 0 during reset and do not assert until the FETCH handshake completes.
